// File: rtl/serial_in_if.sv
// serial_in_if: receive-side byte handshake of the serial_in UART receiver.
interface serial_in_if;
    logic [7:0] char;
    logic       valid;
    logic       ready;
    logic       overrun;
    logic       frame_err;
    modport master(output char, valid, overrun, frame_err, input ready);
    modport slave(input char, valid, overrun, frame_err, output ready);
endinterface

// File: rtl/serial_in.sv
// serial_in: 8N1 UART receiver with a small byte FIFO and a valid/ready output.
// Define SERIAL_IN_PARITY_EN for 8E1 framing with parity checking.
module serial_in #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    serial_in_if.master bus
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef SERIAL_IN_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
    state_t state, state_n;
    logic [1:0] rx_s;
    logic rx, tick, push, ferr, pop, full, wr;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] data, data_n, last;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rp, wp;
    logic [AW:0] fcnt;
`ifdef SERIAL_IN_PARITY_EN
    logic par_bad, par_bad_n;
`endif
    assign rx = rx_s[1];
    assign tick = cnt == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s  <= 2'b11;
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            data  <= '0;
`ifdef SERIAL_IN_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            rx_s  <= {rx_s[0], uart_rx};
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            data  <= data_n;
`ifdef SERIAL_IN_PARITY_EN
            par_bad <= par_bad_n;
`endif
        end
    end
    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = data;
        push    = 1'b0;
        ferr    = 1'b0;
        cnt_n   = (state == IDLE || state == BREAK) ? cnt : (tick ? CW'(CPB - 1) : cnt - 1'b1);
`ifdef SERIAL_IN_PARITY_EN
        par_bad_n = par_bad;
`endif
        case (state)
            IDLE: if (!rx) begin
                state_n = START;
                cnt_n   = CW'(CPB / 2 - 1);
            end
            START: if (tick) begin
                state_n = rx ? IDLE : DATA;
                idx_n   = '0;
            end
            DATA: if (tick) begin
                data_n = {rx, data[7:1]};
                idx_n  = idx + 3'd1;
`ifdef SERIAL_IN_PARITY_EN
                if (idx == 3'd7) state_n = PARITY;
            end
            PARITY: if (tick) begin
                par_bad_n = ^data ^ rx;
                state_n   = STOP;
            end
            STOP: if (tick) begin
                state_n = rx ? IDLE : BREAK;
                push    = rx & ~par_bad;
                ferr    = ~rx | par_bad;
            end
`else
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (tick) begin
                state_n = rx ? IDLE : BREAK;
                push    = rx;
                ferr    = ~rx;
            end
`endif
            BREAK: if (rx) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign full = fcnt == (AW + 1)'(FIFO_DEPTH);
    assign pop  = bus.valid & bus.ready;
    assign wr   = push & (~full | pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp   <= '0;
            wp   <= '0;
            fcnt <= '0;
            last <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) begin
                rp   <= rp + 1'b1;
                last <= mem[rp];
            end
            fcnt <= fcnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk)
        if (wr) mem[wp] <= data;
    assign bus.valid     = fcnt != '0;
    assign bus.char      = bus.valid ? mem[rp] : last;
    assign bus.overrun   = push & full & ~pop;
    assign bus.frame_err = ferr;
endmodule

// File: tb/tb_serial_in.sv
// tb_serial_in: directed-vector bench for serial_in at 16 clocks per bit.
module tb_serial_in;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ferr_n = 0, ovr_n = 0, vcyc_n = 0, vrise = 0;
    logic v_prev = 1'b0;
    logic [7:0] rxq[$];
    int t0, lat, f0, o0, v0;

    serial_in_if bus();
    serial_in #(.CLK_FREQ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid && bus.ready) rxq.push_back(bus.char);
        if (bus.frame_err) ferr_n++;
        if (bus.overrun) ovr_n++;
        if (bus.valid) vcyc_n++;
        if (bus.valid && !v_prev) vrise = cyc;
        v_prev = bus.valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        uart_rx = 1'b0;
        clks(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            clks(16);
        end
`ifdef SERIAL_IN_PARITY_EN
        uart_rx = ^d ^ par_flip;
        clks(16);
`endif
        uart_rx = stop_bit;
        clks(16);
        uart_rx = 1'b1;
    endtask

    initial begin
        bus.ready = 1'b1;
        clks(4);
        @(negedge clk);
        check("rst_valid", bus.valid, 0);
        check("rst_char", bus.char, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_frame_err", bus.frame_err, 0);
        clks(1);
        rst = 1'b0;
        clks(20);

        // 1: single good byte
        rxq.delete();
        v0 = vcyc_n; f0 = ferr_n; o0 = ovr_n;
        t0 = cyc;
        send(8'h41, 1'b1, 1'b0);
        clks(20);
        lat = vrise - t0;
        check("t1_count", rxq.size(), 1);
        check("t1_char", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h41);
        check("t1_latency_window", (lat >= 150 && lat <= 158), 1);
        check("t1_valid_cycles", vcyc_n - v0, 1);
        check("t1_frame_err", ferr_n - f0, 0);
        check("t1_overrun", ovr_n - o0, 0);

        // 2: short glitch on the line
        rxq.delete();
        v0 = vcyc_n; f0 = ferr_n; o0 = ovr_n;
        uart_rx = 1'b0;
        clks(4);
        uart_rx = 1'b1;
        clks(40);
        check("t2_valid_cycles", vcyc_n - v0, 0);
        check("t2_frame_err", ferr_n - f0, 0);
        check("t2_overrun", ovr_n - o0, 0);

        // 3: bad stop bit, held break, then recovery
        rxq.delete();
        f0 = ferr_n;
        send(8'h55, 1'b0, 1'b0);
        uart_rx = 1'b0;
        clks(48);
        uart_rx = 1'b1;
        clks(32);
        check("t3_frame_err_mid", ferr_n - f0, 1);
        check("t3_count_mid", rxq.size(), 0);
        send(8'h0A, 1'b1, 1'b0);
        clks(20);
        check("t3_frame_err", ferr_n - f0, 1);
        check("t3_count", rxq.size(), 1);
        check("t3_char", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h0A);

        // 4: fill FIFO with ready low, overflow once, then drain
        bus.ready = 1'b0;
        o0 = ovr_n; f0 = ferr_n;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
        clks(20);
        check("t4_overrun", ovr_n - o0, 1);
        check("t4_frame_err", ferr_n - f0, 0);
        @(negedge clk);
        check("t4_valid_held", bus.valid, 1);
        check("t4_char_held", bus.char, 8'h01);
        clks(1);
        bus.ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("t4_pop%0d_valid", i), bus.valid, 1);
            check($sformatf("t4_pop%0d_char", i), bus.char, 8'(i));
            clks(1);
        end
        @(negedge clk);
        check("t4_drained", bus.valid, 0);
        check("t4_char_last", bus.char, 8'h04);
        clks(4);

        // 5: reset mid-frame during data bit 3 of 0x3C
        rxq.delete();
        f0 = ferr_n;
        uart_rx = 1'b0;
        clks(16);
        for (int i = 0; i < 3; i++) begin
            uart_rx = (i == 2);
            clks(16);
        end
        uart_rx = 1'b1;
        clks(8);
        rst = 1'b1;
        clks(2);
        @(negedge clk);
        check("t5_rst_valid", bus.valid, 0);
        check("t5_rst_char", bus.char, 0);
        check("t5_rst_overrun", bus.overrun, 0);
        check("t5_rst_frame_err", bus.frame_err, 0);
        clks(1);
        rst = 1'b0;
        clks(40);
        send(8'h7E, 1'b1, 1'b0);
        clks(20);
        check("t5_count", rxq.size(), 1);
        check("t5_char", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h7E);
        check("t5_frame_err", ferr_n - f0, 0);

`ifdef SERIAL_IN_PARITY_EN
        // 6: parity good then parity bad
        rxq.delete();
        f0 = ferr_n; v0 = vcyc_n;
        send(8'h03, 1'b1, 1'b0);
        clks(20);
        check("t6_good_count", rxq.size(), 1);
        check("t6_good_char", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h03);
        check("t6_good_frame_err", ferr_n - f0, 0);
        v0 = vcyc_n;
        send(8'h03, 1'b1, 1'b1);
        clks(20);
        check("t6_bad_frame_err", ferr_n - f0, 1);
        check("t6_bad_valid_cycles", vcyc_n - v0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
